// File: rtl/hazard_stall_ctrl_if.sv
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Pipeline-side bundle for the hazard/stall controller.
//               'slave' is the controller view and 'master' the pipeline view.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_stall_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [4:0]       ex_rd;
    logic             ex_regwrite;
    logic             ex_is_load;
    logic [1:0]       ex_pcsrc;
    logic [4:0]       mem_rd;
    logic             mem_regwrite;
    logic             mem_req;
    logic             mem_ready;
    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             idex_stall;
    logic             idex_flush;
    logic             exmem_stall;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;

    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_is_load,
               ex_pcsrc, mem_rd, mem_regwrite, mem_req, mem_ready,
        input  pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               mem_timeout, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, ex_rd, ex_regwrite, ex_is_load,
               ex_pcsrc, mem_rd, mem_regwrite, mem_req, mem_ready,
        output pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall,
               mem_timeout, stall_count
    );
endinterface

`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Stall/flush control for the 5-stage core (load-use, redirect,
//               data-memory wait with timeout, saturating stall counter).
//               Macro HAZ_FWD_EN: forwarding present, only load-use stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_stall_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    hazard_stall_ctrl_if.slave bus
);

    localparam int c_WAIT_W = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [c_WAIT_W-1:0] w_wait_nxt;
    logic                w_set_timeout;
    logic                r_mem_timeout;
    logic [CNT_W-1:0]    r_stall_count;

    logic w_redirect;
    logic w_memwait;
    logic w_raw;
    logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall, w_idex_flush, w_exmem_stall;

    function automatic logic f_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rs,
                                     input logic use_rt);
        return (x != 5'd0) && ((use_rs && rs == x) || (use_rt && rt == x));
    endfunction

    assign w_redirect = (bus.ex_pcsrc != 2'b00);
    assign w_memwait  = bus.mem_req && !bus.mem_ready;

`ifdef HAZ_FWD_EN
    logic w_unused;
    assign w_unused = ^{bus.mem_rd, bus.mem_regwrite};
    assign w_raw = bus.ex_regwrite && bus.ex_is_load &&
                   f_match(bus.ex_rd, bus.id_rs, bus.id_rt, bus.id_use_rs, bus.id_use_rt);
`else
    logic w_unused;
    assign w_unused = bus.ex_is_load;
    // Without forwarding any in-flight producer in EX or MEM must be waited out.
    assign w_raw = (bus.ex_regwrite &&
                    f_match(bus.ex_rd, bus.id_rs, bus.id_rt, bus.id_use_rs, bus.id_use_rt)) ||
                   (bus.mem_regwrite &&
                    f_match(bus.mem_rd, bus.id_rs, bus.id_rt, bus.id_use_rs, bus.id_use_rt));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= '0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state    <= w_next_state;
            r_wait_cnt <= w_wait_nxt;
            if (w_set_timeout)
                r_mem_timeout <= 1'b1;
            if (w_pc_stall && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + 1'b1;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_set_timeout = 1'b0;
        w_pc_stall    = 1'b0;
        w_ifid_stall  = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_stall  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_stall = 1'b0;

        // Freeze-everything cases are handled first; the pipeline rules follow.
        if ((r_state == ST_HALT) || (r_state == ST_MEM_WAIT && !bus.mem_ready) ||
            (r_state == ST_RUN && w_memwait)) begin
            w_pc_stall    = 1'b1;
            w_ifid_stall  = 1'b1;
            w_idex_stall  = 1'b1;
            w_exmem_stall = 1'b1;
        end else if (w_redirect) begin
            w_ifid_flush = 1'b1;
            w_idex_flush = 1'b1;
        end else if (w_raw) begin
            w_pc_stall   = 1'b1;
            w_ifid_stall = 1'b1;
            w_idex_flush = 1'b1;
        end

        case (r_state)
            ST_RUN: begin
                if (w_memwait) begin
                    w_wait_nxt = c_WAIT_W'(1);
                    if (MAX_WAIT <= 1) begin
                        w_next_state  = ST_HALT;
                        w_set_timeout = 1'b1;
                    end else begin
                        w_next_state = ST_MEM_WAIT;
                    end
                end
            end
            ST_MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    w_wait_nxt = r_wait_cnt + 1'b1;
                    if (w_wait_nxt >= c_WAIT_W'(MAX_WAIT)) begin
                        w_next_state  = ST_HALT;
                        w_set_timeout = 1'b1;
                    end
                end else begin
                    w_next_state = ST_RUN;
                    w_wait_nxt   = '0;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_RUN;
                w_wait_nxt   = '0;
            end
        endcase
    end

    assign bus.pc_stall    = w_pc_stall;
    assign bus.ifid_stall  = w_ifid_stall;
    assign bus.ifid_flush  = w_ifid_flush;
    assign bus.idex_stall  = w_idex_stall;
    assign bus.idex_flush  = w_idex_flush;
    assign bus.exmem_stall = w_exmem_stall;
    assign bus.mem_timeout = r_mem_timeout;
    assign bus.stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Directed + random bench for hazard_stall_ctrl against a
//               cycle-level reference model (default and 4-bit counter DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.CNT_W(16)) bus ();
    hazard_stall_ctrl_if #(.CNT_W(4))  bus4 ();

    hazard_stall_ctrl #(.MAX_WAIT(16), .CNT_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));
    hazard_stall_ctrl #(.MAX_WAIT(16), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4));

    assign bus4.id_rs        = bus.id_rs;
    assign bus4.id_rt        = bus.id_rt;
    assign bus4.id_use_rs    = bus.id_use_rs;
    assign bus4.id_use_rt    = bus.id_use_rt;
    assign bus4.ex_rd        = bus.ex_rd;
    assign bus4.ex_regwrite  = bus.ex_regwrite;
    assign bus4.ex_is_load   = bus.ex_is_load;
    assign bus4.ex_pcsrc     = bus.ex_pcsrc;
    assign bus4.mem_rd       = bus.mem_rd;
    assign bus4.mem_regwrite = bus.mem_regwrite;
    assign bus4.mem_req      = bus.mem_req;
    assign bus4.mem_ready    = bus.mem_ready;

    int total = 0;
    int bad   = 0;

    // Reference model: how many cycles the current memory access has waited,
    // whether the core is halted, and the expected counters.
    int m_waited  = 0;
    bit m_halted  = 0;
    bit m_timeout = 0;
    int m_cnt     = 0;
    int m_cnt4    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit reads(input logic [4:0] x);
        return (x != 0) && ((bus.id_use_rs && bus.id_rs == x) || (bus.id_use_rt && bus.id_rt == x));
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall}
    function automatic logic [5:0] expect_ctl();
        bit raw;
`ifdef HAZ_FWD_EN
        raw = bus.ex_regwrite && bus.ex_is_load && reads(bus.ex_rd);
`else
        raw = (bus.ex_regwrite && reads(bus.ex_rd)) || (bus.mem_regwrite && reads(bus.mem_rd));
`endif
        if (m_halted) return 6'b110101;
        if (!bus.mem_ready && (m_waited > 0 || bus.mem_req)) return 6'b110101;
        if (bus.ex_pcsrc != 0) return 6'b001010;
        if (raw) return 6'b110010;
        return 6'b000000;
    endfunction

    task automatic set_idle();
        bus.id_rs = 0; bus.id_rt = 0; bus.id_use_rs = 0; bus.id_use_rt = 0;
        bus.ex_rd = 0; bus.ex_regwrite = 0; bus.ex_is_load = 0; bus.ex_pcsrc = 0;
        bus.mem_rd = 0; bus.mem_regwrite = 0; bus.mem_req = 0; bus.mem_ready = 0;
    endtask

    // Inputs are already applied; check the combinational controls, clock once,
    // advance the model and check the registered outputs.
    task automatic step(input string tag);
        logic [5:0] exp, obs;
        exp = expect_ctl();
        #2;
        obs = {bus.pc_stall, bus.ifid_stall, bus.ifid_flush,
               bus.idex_stall, bus.idex_flush, bus.exmem_stall};
        chk({tag, ".ctl"}, 32'(obs), 32'(exp));
        chk({tag, ".excl"}, 32'((bus.idex_stall & bus.idex_flush) | (bus.ifid_stall & bus.ifid_flush)), 0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_waited = 0; m_halted = 0; m_timeout = 0; m_cnt = 0; m_cnt4 = 0;
        end else begin
            if (exp[5]) begin
                if (m_cnt < 65535) m_cnt++;
                if (m_cnt4 < 15) m_cnt4++;
            end
            if (!m_halted) begin
                if (m_waited > 0) begin
                    if (!bus.mem_ready) begin
                        m_waited++;
                        if (m_waited >= 16) begin
                            m_halted  = 1;
                            m_timeout = 1;
                        end
                    end else begin
                        m_waited = 0;
                    end
                end else if (bus.mem_req && !bus.mem_ready) begin
                    m_waited = 1;
                end
            end
        end
        chk({tag, ".timeout"}, 32'(bus.mem_timeout), 32'(m_timeout));
        chk({tag, ".count"}, 32'(bus.stall_count), 32'(m_cnt));
        chk({tag, ".count4"}, 32'(bus4.stall_count), 32'(m_cnt4));
    endtask

    task automatic do_reset(input string tag);
        set_idle();
        rst = 1'b1;
        step(tag);
        rst = 1'b0;
    endtask

    initial begin
        set_idle();
        @(posedge clk);
        #1;
        do_reset("reset");
        chk("reset_count", 32'(bus.stall_count), 0);

        // Load-use on rs: single bubble, then the pipeline moves on.
        bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_use_rs = 1;
        step("load_use");
        chk("load_use_count", 32'(bus.stall_count), 1);
        set_idle();
        step("after_load_use");

        // Register 0 never matches.
        bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_rd = 0; bus.id_rs = 0; bus.id_use_rs = 1;
        step("reg0");

        // Redirect beats a simultaneous load-use.
        bus.ex_is_load = 1; bus.ex_regwrite = 1; bus.ex_rd = 5; bus.id_rs = 5; bus.id_use_rs = 1;
        bus.ex_pcsrc = 2'b01;
        step("redirect");
        set_idle();

        // Three-cycle memory wait, released on the fourth.
        do_reset("reset2");
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 3; i++) step("memwait");
        bus.mem_ready = 1;
        step("memdone");
        chk("memwait_count", 32'(bus.stall_count), 3);
        set_idle();
        step("after_mem");

        // Timeout: 16 wait cycles halt the core; rst is the only way out.
        do_reset("reset3");
        bus.mem_req = 1; bus.mem_ready = 0;
        for (int i = 0; i < 16; i++) step("timeout_wait");
        chk("timeout_flag", 32'(bus.mem_timeout), 1);
        bus.mem_req = 0; bus.mem_ready = 1;
        for (int i = 0; i < 4; i++) step("halted");
        chk("sat_count4", 32'(bus4.stall_count), 15);
        chk("halt_count", 32'(bus.stall_count), 20);
        do_reset("reset4");
        chk("reset4_timeout", 32'(bus.mem_timeout), 0);
        step("post_reset_idle");

        // ALU producer of r7 moving EX -> MEM while the consumer waits in ID.
        bus.ex_regwrite = 1; bus.ex_is_load = 0; bus.ex_rd = 7; bus.id_rt = 7; bus.id_use_rt = 1;
        step("fwd_ex");
        bus.ex_regwrite = 0; bus.ex_rd = 0; bus.mem_regwrite = 1; bus.mem_rd = 7;
        step("fwd_mem");
        bus.mem_regwrite = 0; bus.mem_rd = 0;
        step("fwd_clear");

        // Random traffic over a small register range so hazards are frequent.
        for (int n = 0; n < 500; n++) begin
            rst              = ($urandom_range(0, 59) == 0);
            bus.id_rs        = 5'($urandom_range(0, 3));
            bus.id_rt        = 5'($urandom_range(0, 3));
            bus.id_use_rs    = 1'($urandom);
            bus.id_use_rt    = 1'($urandom);
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.ex_regwrite  = 1'($urandom);
            bus.ex_is_load   = 1'($urandom);
            bus.ex_pcsrc     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            bus.mem_rd       = 5'($urandom_range(0, 3));
            bus.mem_regwrite = 1'($urandom);
            bus.mem_req      = ($urandom_range(0, 2) == 0);
            bus.mem_ready    = ($urandom_range(0, 9) < 4);
            step("rand");
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
